// File: rtl/itimer_pkg.sv
// rtl/itimer_pkg.sv - mode encodings and prescaler width helper for the interval timer
package itimer_pkg;

  localparam logic [1:0] C_TIM_0001T = 2'b00;
  localparam logic [1:0] C_TIM_0008T = 2'b01;
  localparam logic [1:0] C_TIM_0064T = 2'b10;
  localparam logic [1:0] C_TIM_1024T = 2'b11;

  // Prescaler width is the largest shift, kept at least 1 bit so the counter always exists.
  function automatic int div_w(input int s0, input int s1, input int s2, input int s3);
    int m;
    m = s0;
    if (s1 > m) m = s1;
    if (s2 > m) m = s2;
    if (s3 > m) m = s3;
    if (m < 1) m = 1;
    return m;
  endfunction

endpackage

// File: rtl/itimer_presc.sv
// rtl/itimer_presc.sv - free-running prescaler with sync clear and mode-selected tick
module itimer_presc
  import itimer_pkg::*;
#(
  parameter int DIV_W = 10,
  parameter int SH0   = 0,
  parameter int SH1   = 3,
  parameter int SH2   = 6,
  parameter int SH3   = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic [1:0] mode_i,
  output logic       tick_o
);

  localparam logic [DIV_W-1:0] M0 = DIV_W'((64'd1 << SH0) - 64'd1);
  localparam logic [DIV_W-1:0] M1 = DIV_W'((64'd1 << SH1) - 64'd1);
  localparam logic [DIV_W-1:0] M2 = DIV_W'((64'd1 << SH2) - 64'd1);
  localparam logic [DIV_W-1:0] M3 = DIV_W'((64'd1 << SH3) - 64'd1);

  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] mask;

  always_comb begin
    presc_d = clr_i ? '0 : presc_q + DIV_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  // A zero shift yields an empty mask, so the compare is always true: tick every cycle.
  always_comb begin
    mask = M0;
    case (mode_i)
      C_TIM_0001T: mask = M0;
      C_TIM_0008T: mask = M1;
      C_TIM_0064T: mask = M2;
      C_TIM_1024T: mask = M3;
      default:     mask = M0;
    endcase
  end

  assign tick_o = ((presc_q & mask) == mask);

endmodule

// File: rtl/itimer_n.sv
// rtl/itimer_n.sv - 6532-style interval timer top; ITIMER_N_IRQ_EN enables the IE/IRQ path
module itimer_n
  import itimer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SH0   = 0,
  parameter int SH1   = 3,
  parameter int SH2   = 6,
  parameter int SH3   = 10
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             WE,
  input  logic [1:0]       MODE,
  input  logic [WIDTH-1:0] IN,
  input  logic             IE,
  input  logic             FLAG_CLR,
  output logic [WIDTH-1:0] OUT,
  output logic             FLAG,
  output logic             IRQ
);

  localparam int DIV_W = div_w(SH0, SH1, SH2, SH3);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             fast_q, fast_d;
  logic             flag_q, flag_d;
  logic             presc_tick;
  logic             tick;
  logic             underflow;

  itimer_presc #(
    .DIV_W (DIV_W),
    .SH0   (SH0),
    .SH1   (SH1),
    .SH2   (SH2),
    .SH3   (SH3)
  ) u_presc (
    .clk_i  (CLK),
    .rst_i  (RES),
    .clr_i  (WE),
    .mode_i (mode_q),
    .tick_o (presc_tick)
  );

  assign tick      = fast_q | presc_tick;
  assign underflow = tick && (cnt_q == '0);

  // Load beats everything; otherwise an underflow setting FLAG beats a same-cycle clear.
  always_comb begin
    cnt_d  = cnt_q;
    mode_d = mode_q;
    fast_d = fast_q;
    flag_d = flag_q;
    if (WE) begin
      cnt_d  = IN;
      mode_d = MODE;
      fast_d = 1'b0;
      flag_d = 1'b0;
    end else begin
      if (tick) cnt_d = cnt_q - WIDTH'(1);
      if (underflow) begin
        fast_d = 1'b1;
        flag_d = 1'b1;
      end else if (FLAG_CLR) begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      cnt_q  <= '0;
      mode_q <= C_TIM_0001T;
      fast_q <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      fast_q <= fast_d;
      flag_q <= flag_d;
    end
  end

`ifdef ITIMER_N_IRQ_EN
  logic ie_q;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES)     ie_q <= 1'b0;
    else if (WE) ie_q <= IE;
  end

  assign IRQ = flag_q & ie_q;
`else
  logic unused_ie;
  assign unused_ie = IE;
  assign IRQ       = 1'b0;
`endif

  assign OUT  = cnt_q;
  assign FLAG = flag_q;

endmodule

// File: tb/tb_itimer_n.sv
// tb/tb_itimer_n.sv - self-checking bench: per-cycle model compare plus directed literal checks
module tb_itimer_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        a_we = 1'b0, a_ie = 1'b0, a_clr = 1'b0;
  logic [1:0]  a_mode = 2'b00;
  logic [7:0]  a_in = 8'h00;
  logic [7:0]  a_out;
  logic        a_flag, a_irq;

  logic        b_we = 1'b0, b_ie = 1'b0, b_clr = 1'b0;
  logic [1:0]  b_mode = 2'b00;
  logic [15:0] b_in = 16'h0000;
  logic [15:0] b_out;
  logic        b_flag, b_irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  itimer_n u_a (
    .CLK(clk), .RES(rst), .WE(a_we), .MODE(a_mode), .IN(a_in), .IE(a_ie),
    .FLAG_CLR(a_clr), .OUT(a_out), .FLAG(a_flag), .IRQ(a_irq)
  );

  itimer_n #(.WIDTH(16), .SH3(12)) u_b (
    .CLK(clk), .RES(rst), .WE(b_we), .MODE(b_mode), .IN(b_in), .IE(b_ie),
    .FLAG_CLR(b_clr), .OUT(b_out), .FLAG(b_flag), .IRQ(b_irq)
  );

  // Model: a count of edges since the last load decides when the prescaled rate fires.
  typedef struct {
    longint cnt;
    int     mode;
    bit     fast;
    bit     flag;
    bit     ie;
    longint since_load;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.cnt = 0; m.mode = 0; m.fast = 0; m.flag = 0; m.ie = 0; m.since_load = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit we, int md, longint inv, bit ie, bit clr,
                                    int w, int sh);
    bit     fires;
    longint period;
    if (we) begin
      m.cnt = inv; m.mode = md; m.ie = ie; m.fast = 0; m.flag = 0; m.since_load = 0;
      return m;
    end
    period = longint'(1) << sh;
    fires  = m.fast || ((m.since_load % period) == period - 1);
    m.since_load++;
    if (fires && m.cnt == 0) begin
      m.cnt  = (longint'(1) << w) - 1;
      m.fast = 1;
      m.flag = 1;
    end else begin
      if (fires) m.cnt = m.cnt - 1;
      if (clr) m.flag = 0;
    end
    return m;
  endfunction

  function automatic int sh_a(int md);
    case (md) 0: return 0; 1: return 3; 2: return 6; default: return 10; endcase
  endfunction

  function automatic int sh_b(int md);
    case (md) 0: return 0; 1: return 3; 2: return 6; default: return 12; endcase
  endfunction

  function automatic bit irq_exp(mdl_t m);
`ifdef ITIMER_N_IRQ_EN
    return m.flag & m.ie;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, a_we, int'(a_mode), longint'(a_in), a_ie, a_clr, 8, sh_a(ma.mode));
      mb = mdl_step(mb, b_we, int'(b_mode), longint'(b_in), b_ie, b_clr, 16, sh_b(mb.mode));
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("a_out_model",  longint'(a_out),  ma.cnt);
    check("a_flag_model", longint'(a_flag), longint'(ma.flag));
    check("a_irq_model",  longint'(a_irq),  longint'(irq_exp(ma)));
    check("b_out_model",  longint'(b_out),  mb.cnt);
    check("b_flag_model", longint'(b_flag), longint'(mb.flag));
    check("b_irq_model",  longint'(b_irq),  longint'(irq_exp(mb)));
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns at the falling edge after the load edge (edge 0).
  task automatic load_a(input logic [7:0] v, input logic [1:0] md, input logic ie);
    @(negedge clk);
    a_we = 1'b1; a_in = v; a_mode = md; a_ie = ie;
    @(negedge clk);
    a_we = 1'b0;
  endtask

  bit irq_on;

  initial begin
`ifdef ITIMER_N_IRQ_EN
    irq_on = 1'b1;
`else
    irq_on = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out",  longint'(a_out),  0);
    check("rst_flag", longint'(a_flag), 0);
    check("rst_irq",  longint'(a_irq),  0);
    rst = 1'b0;
    adv(1);
    check("post_rst_out",  longint'(a_out),  8'hFF);
    check("post_rst_flag", longint'(a_flag), 1);
    adv(1);
    check("post_rst_out2", longint'(a_out), 8'hFE);

    load_a(8'h05, 2'b01, 1'b0);
    check("m1_e0", longint'(a_out), 8'h05);
    adv(7);  check("m1_e7",  longint'(a_out), 8'h05);
    adv(1);  check("m1_e8",  longint'(a_out), 8'h04);
    adv(32); check("m1_e40", longint'(a_out), 8'h00);
    adv(7);  check("m1_e47", longint'(a_out), 8'h00);
             check("m1_e47_flag", longint'(a_flag), 0);
    adv(1);  check("m1_e48", longint'(a_out), 8'hFF);
             check("m1_e48_flag", longint'(a_flag), 1);
    adv(1);  check("m1_e49", longint'(a_out), 8'hFE);
    adv(1);  check("m1_e50", longint'(a_out), 8'hFD);

    #2 rst = 1'b1;
    #1;
    check("midrst_out",  longint'(a_out),  0);
    check("midrst_flag", longint'(a_flag), 0);
    check("midrst_irq",  longint'(a_irq),  0);
    @(negedge clk);
    rst = 1'b0;
    adv(1);
    check("rel_out",  longint'(a_out),  8'hFF);
    check("rel_flag", longint'(a_flag), 1);

    load_a(8'h02, 2'b11, 1'b1);
    adv(1023); check("m3_e1023", longint'(a_out), 8'h02);
    adv(1);    check("m3_e1024", longint'(a_out), 8'h01);
    adv(1024); check("m3_e2048", longint'(a_out), 8'h00);
    adv(1023); check("m3_e3071_flag", longint'(a_flag), 0);
    adv(1);    check("m3_e3072", longint'(a_out), 8'hFF);
               check("m3_e3072_flag", longint'(a_flag), 1);
               check("m3_e3072_irq",  longint'(a_irq), longint'(irq_on));
    @(negedge clk); a_clr = 1'b1;
    @(negedge clk); a_clr = 1'b0;
    check("clr_flag", longint'(a_flag), 0);
    check("clr_irq",  longint'(a_irq),  0);
    check("clr_out",  longint'(a_out),  8'hFE);
    adv(254); check("m3_e3327", longint'(a_out), 8'h00);
              check("m3_e3327_flag", longint'(a_flag), 0);
    adv(1);   check("m3_e3328_flag", longint'(a_flag), 1);
              check("m3_e3328_irq",  longint'(a_irq), longint'(irq_on));
    @(negedge clk); a_clr = 1'b1;
    @(negedge clk); a_clr = 1'b0;
    check("clr2_flag", longint'(a_flag), 0);
    adv(254);
    @(negedge clk); a_clr = 1'b1;
    adv(1);
    check("clr_vs_uf_flag", longint'(a_flag), 1);
    check("clr_vs_uf_out",  longint'(a_out),  8'hFF);
    @(negedge clk); a_clr = 1'b0;

    load_a(8'h33, 2'b00, 1'b0);
    check("we_tick_out",  longint'(a_out),  8'h33);
    check("we_tick_flag", longint'(a_flag), 0);
    adv(1); check("we_tick_next", longint'(a_out), 8'h32);

    load_a(8'h00, 2'b01, 1'b0);
    adv(7); check("zero_e7", longint'(a_out), 8'h00);
            check("zero_e7_flag", longint'(a_flag), 0);
    adv(1); check("zero_e8", longint'(a_out), 8'hFF);
            check("zero_e8_flag", longint'(a_flag), 1);

    @(negedge clk);
    b_we = 1'b1; b_in = 16'h0001; b_mode = 2'b11; b_ie = 1'b1;
    @(negedge clk);
    b_we = 1'b0;
    adv(4095); check("w16_e4095", longint'(b_out), 16'h0001);
    adv(1);    check("w16_e4096", longint'(b_out), 16'h0000);
    adv(4095); check("w16_e8191_flag", longint'(b_flag), 0);
    adv(1);    check("w16_e8192", longint'(b_out), 16'hFFFF);
               check("w16_e8192_flag", longint'(b_flag), 1);
               check("w16_e8192_irq",  longint'(b_irq), longint'(irq_on));

    adv(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
